task3_divmod: RTL and testbench

Iterative unsigned divider that inverts the multiply-accumulate datapath `data_out = A*B + C`. It takes a 2*SIZE-bit accumulated word and a SIZE-bit divisor, and returns the quotient and the remainder. When C < B it therefore recovers A and C. It is a restoring shift-subtract engine that retires one quotient bit per clock, and it sits downstream of the MAC pipeline behind a start/ready/done handshake.

---
 rtl/task3_divmod_if.sv | 47 ++++
 rtl/task3_divmod.sv | 153 +++++++++++++++
 tb/tb_task3_divmod.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/task3_divmod_if.sv
`default_nettype none
// ============================================================================
//  Module      : task3_divmod_if
//  Description : Start/ready/done handshake and result bus between a
//                requester (master) and the task3_divmod engine (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface task3_divmod_if #(
   parameter int SIZE = 8
);

   // Request side: sampled by the engine only while ready is high
   logic                  start;
   logic [2*SIZE-1:0]     dividend;
   logic [SIZE-1:0]       divisor;

   // Status and registered results
   logic                  ready;
   logic                  done;
   logic [2*SIZE-1:0]     quotient;
   logic [SIZE-1:0]       remainder;
   logic                  div_by_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  ready,
      input  done,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output ready,
      output done,
      output quotient,
      output remainder,
      output div_by_zero
   );

endinterface : task3_divmod_if
`default_nettype wire

// File: rtl/task3_divmod.sv
`default_nettype none
// ============================================================================
//  Module      : task3_divmod
//  Description : Iterative restoring unsigned divider. Divides a 2*SIZE-bit
//                word by a SIZE-bit divisor, one quotient bit per clock,
//                behind a start/ready/done handshake. Recovers A and C from
//                a MAC result A*B+C when C < B.
//  Revision    : 1.0 - initial release
// ============================================================================
module task3_divmod #(
   parameter int SIZE = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   task3_divmod_if.slave     bus
);

   // Counter must hold the value 2*SIZE
   localparam int CNT_W = $clog2(2*SIZE + 1);

   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(2*SIZE);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [1:0]          state_q,  state_d;
   // Dividend shift register; quotient bits enter at the LSB as dividend
   // bits leave at the MSB, so after 2*SIZE shifts it holds the quotient.
   logic [2*SIZE-1:0]   dvd_q,    dvd_d;
   logic [SIZE-1:0]     dsr_q,    dsr_d;
   logic [SIZE:0]       part_q,   part_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic                zdiv_q,   zdiv_d;

   // Result registers, visible on the bus
   logic                done_q,   done_d;
   logic [2*SIZE-1:0]   quo_q,    quo_d;
   logic [SIZE-1:0]     rem_q,    rem_d;
   logic                dbz_q,    dbz_d;

   // ------------------------------------------------------------------------
   // One restoring iteration
   // ------------------------------------------------------------------------
   logic [SIZE+1:0]     w_shift;
   logic [SIZE:0]       w_trial;
   logic                w_ge;
   logic [SIZE:0]       w_part_next;
   logic [2*SIZE-1:0]   w_dvd_next;

   // The shifted partial is kept one bit wider than the stored partial so
   // the compare stays exact even when the divisor is zero and the partial
   // keeps growing; the stored partial simply drops that extra bit.
   assign w_shift     = {part_q, dvd_q[2*SIZE-1]};
   assign w_ge        = (w_shift >= {2'b00, dsr_q});
   assign w_trial     = w_shift[SIZE:0] - {1'b0, dsr_q};
   assign w_part_next = w_ge ? w_trial : w_shift[SIZE:0];
   assign w_dvd_next  = {dvd_q[2*SIZE-2:0], w_ge};

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.ready       = (state_q == S_IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

   // Next-state logic for the control FSM and the shift-subtract datapath
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      part_d  = part_q;
      cnt_d   = cnt_q;
      zdiv_d  = zdiv_q;
      done_d  = 1'b0;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dvd_d   = bus.dividend;
               dsr_d   = bus.divisor;
               part_d  = '0;
               cnt_d   = C_CNT_LOAD;
               zdiv_d  = (bus.divisor == '0);
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            dvd_d  = w_dvd_next;
            part_d = w_part_next;
            cnt_d  = cnt_q - C_CNT_LAST;
            if (cnt_q == C_CNT_LAST) begin
               // With a zero divisor every trial succeeds, so the shifted
               // word is already all ones and the partial ends up holding
               // the low dividend bits; the quotient is still forced so the
               // zero-divisor result never depends on that side effect.
               quo_d   = zdiv_q ? '1 : w_dvd_next;
               rem_d   = w_part_next[SIZE-1:0];
               dbz_d   = zdiv_q;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register update; reset aborts any operation in flight without a done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dsr_q   <= '0;
         part_q  <= '0;
         cnt_q   <= '0;
         zdiv_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         part_q  <= part_d;
         cnt_q   <= cnt_d;
         zdiv_q  <= zdiv_d;
         done_q  <= done_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

endmodule : task3_divmod
`default_nettype wire

// File: tb/tb_task3_divmod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_task3_divmod
//  Description : Self-checking bench for task3_divmod (SIZE=8): directed
//                vector table, multi-cycle handshake/reset sequences and
//                randomized back-to-back operations against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_task3_divmod;

   localparam int SIZE = 8;

   logic clk;
   logic rst_n;

   task3_divmod_if #(.SIZE(SIZE)) bus ();

   task3_divmod #(.SIZE(SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk;
   int          n_fail;
   logic [15:0] last_q;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dsr;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
   } vec_t;

   vec_t tbl [9];

   // Step to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One complete operation with latency, pulse width and result checks
   task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dsr,
                         input logic [15:0] eq, input logic [7:0] er, input logic edz);
      int w;
      int lat;
      w = 0;
      while (!bus.ready && w < 40) begin
         tick();
         w++;
      end
      chk({tag, " ready before start"}, 32'(bus.ready), 32'd1);
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dsr;
      tick();
      bus.start    = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
      chk({tag, " ready low after accept"}, 32'(bus.ready), 32'd0);
      chk({tag, " quotient held while busy"}, 32'(bus.quotient), 32'(last_q));
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.done && lat < 40);
      chk({tag, " latency"}, 32'(lat), 32'd16);
      chk({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
      chk({tag, " remainder"}, 32'(bus.remainder), 32'(er));
      chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
      last_q = eq;
      tick();
      chk({tag, " done single cycle"}, 32'(bus.done), 32'd0);
      chk({tag, " ready after done"}, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      int          lat;
      int          seen;
      logic [15:0] rd;
      logic [7:0]  rs;

      n_chk  = 0;
      n_fail = 0;
      last_q = '0;

      tbl[0] = '{16'd2607,  8'd13,   16'd200,    8'd7,    1'b0};
      tbl[1] = '{16'hFFFF,  8'd1,    16'hFFFF,   8'd0,    1'b0};
      tbl[2] = '{16'hFFFF,  8'hFF,   16'd257,    8'd0,    1'b0};
      tbl[3] = '{16'd5,     8'd9,    16'd0,      8'd5,    1'b0};
      tbl[4] = '{16'h1234,  8'd0,    16'hFFFF,   8'h34,   1'b1};
      tbl[5] = '{16'd100,   8'd7,    16'd14,     8'd2,    1'b0};
      tbl[6] = '{16'd0,     8'd5,    16'd0,      8'd0,    1'b0};
      tbl[7] = '{16'hFEFF,  8'hFF,   16'd255,    8'd254,  1'b0};
      tbl[8] = '{16'd0,     8'd0,    16'hFFFF,   8'd0,    1'b1};

      // Reset state
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      tick();
      tick();
      chk("reset ready", 32'(bus.ready), 32'd1);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset quotient", 32'(bus.quotient), 32'd0);
      chk("reset remainder", 32'(bus.remainder), 32'd0);
      chk("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].dvd, tbl[i].dsr, tbl[i].q, tbl[i].r, tbl[i].dz);
      end

      // Start held high through a whole run: accepted again only once ready
      bus.start    = 1'b1;
      bus.dividend = 16'd100;
      bus.divisor  = 8'd7;
      tick();
      bus.dividend = 16'd50;
      bus.divisor  = 8'd5;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.done && lat < 40);
      chk("held first latency", 32'(lat), 32'd16);
      chk("held first quotient", 32'(bus.quotient), 32'd14);
      chk("held first remainder", 32'(bus.remainder), 32'd2);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.done && lat < 60);
      chk("held done spacing", 32'(lat), 32'd18);
      chk("held second quotient", 32'(bus.quotient), 32'd10);
      chk("held second remainder", 32'(bus.remainder), 32'd0);
      chk("held second div_by_zero", 32'(bus.div_by_zero), 32'd0);
      bus.start = 1'b0;
      tick();
      last_q = 16'd10;

      // Asynchronous reset in the middle of cycle 8 of a run
      bus.start    = 1'b1;
      bus.dividend = 16'd2607;
      bus.divisor  = 8'd13;
      tick();
      bus.start = 1'b0;
      repeat (7) tick();
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort ready", 32'(bus.ready), 32'd1);
      chk("abort done", 32'(bus.done), 32'd0);
      chk("abort quotient", 32'(bus.quotient), 32'd0);
      chk("abort remainder", 32'(bus.remainder), 32'd0);
      chk("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         tick();
         if (bus.done) seen++;
      end
      chk("abort no done", 32'(seen), 32'd0);
      last_q = '0;
      run_op("after abort", 16'd2607, 8'd13, 16'd200, 8'd7, 1'b0);

      // Randomized back-to-back operations against arithmetic reference
      for (int k = 0; k < 1000; k++) begin
         rd = 16'($urandom_range(0, 65535));
         rs = 8'($urandom_range(1, 255));
         run_op("rand", rd, rs, rd / 16'(rs), 8'(rd % 16'(rs)), 1'b0);
         chk("rand identity", 32'(bus.quotient) * 32'(bus.divisor == bus.divisor ? rs : rs)
             + 32'(bus.remainder), 32'(rd));
         chk("rand rem bound", 32'(bus.remainder < rs), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_task3_divmod
`default_nettype wire
